// File: rtl/fft16_if.sv
// fft16_if: sample/bin bus of the streaming 16-point FFT.
//
// There is no handshake on this bus. A sample on x_real/x_imag is consumed on
// every rising clock edge, and y_real/y_imag present a new bin on every edge.
// y_first is high during the one cycle in which bin 0 of a frame is shown.
// The producer side (master) drives the samples and receives the bins. The
// FFT side (slave) does the reverse.
interface fft16_if;
    logic [15:0] x_real;
    logic [15:0] x_imag;
    logic [15:0] y_real;
    logic [15:0] y_imag;
    logic        y_first;

    modport master (
        output x_real,
        output x_imag,
        input  y_real,
        input  y_imag,
        input  y_first
    );

    modport slave (
        input  x_real,
        input  x_imag,
        output y_real,
        output y_imag,
        output y_first
    );
endinterface

// File: rtl/fft16.sv
// fft16: streaming 16-point complex DFT with continuous throughput.
//
// Sixteen 38-bit accumulators, one per bin, each collect x[n]*W^(n*k) as the
// samples arrive. On the last sample of a frame the final sums are scaled by
// 2^-19 (twiddle gain 2^15 and 1/16 transform gain) and saturated. Bin 0 goes
// straight to the output. Bins 1..15 are parked in a bank and read out on the
// next 15 clocks, while the accumulators already collect the next frame.
//
// Optional feature: define FFT16_ROUND_EN for round-half-up before the shift.
// Without it the shift truncates (floor).
module fft16 (
    input  logic   clk,
    input  logic   reset,
    fft16_if.slave bus
);

    logic        [3:0]  cnt;
    logic signed [15:0] xr;
    logic signed [15:0] xi;
    logic signed [37:0] acc_re [16];
    logic signed [37:0] acc_im [16];
    logic signed [37:0] sum_re [16];
    logic signed [37:0] sum_im [16];
    logic        [3:0]  m_k    [16];
    logic        [15:0] bank_re [1:15];
    logic        [15:0] bank_im [1:15];
    logic        [15:0] y_re_q;
    logic        [15:0] y_im_q;
    logic               y_first_q;

    assign xr = bus.x_real;
    assign xi = bus.x_imag;

    assign bus.y_real  = y_re_q;
    assign bus.y_imag  = y_im_q;
    assign bus.y_first = y_first_q;

    // cos(2*pi*m/16) scaled by 2^15. sin(2*pi*m/16) is the same table at m-4.
    function automatic logic signed [16:0] cos_lut(input logic [3:0] m);
        case (m)
            4'd0:    cos_lut =  17'sd32768;
            4'd1:    cos_lut =  17'sd30274;
            4'd2:    cos_lut =  17'sd23170;
            4'd3:    cos_lut =  17'sd12540;
            4'd5:    cos_lut = -17'sd12540;
            4'd6:    cos_lut = -17'sd23170;
            4'd7:    cos_lut = -17'sd30274;
            4'd8:    cos_lut = -17'sd32768;
            4'd9:    cos_lut = -17'sd30274;
            4'd10:   cos_lut = -17'sd23170;
            4'd11:   cos_lut = -17'sd12540;
            4'd13:   cos_lut =  17'sd12540;
            4'd14:   cos_lut =  17'sd23170;
            4'd15:   cos_lut =  17'sd30274;
            default: cos_lut =  17'sd0;
        endcase
    endfunction

    function automatic logic signed [16:0] sin_lut(input logic [3:0] m);
        sin_lut = cos_lut(m - 4'd4);
    endfunction

    // 16x17 signed product, sign-extended to accumulator width.
    function automatic logic signed [37:0] mul(input logic signed [15:0] a,
                                               input logic signed [16:0] b);
        logic signed [32:0] p;
        p   = 33'(a) * 33'(b);
        mul = {{5{p[32]}}, p};
    endfunction

    // Scale a frame sum by 2^-19 and saturate to 16-bit signed.
    function automatic logic [15:0] scale(input logic signed [37:0] v);
        logic signed [37:0] t;
        logic signed [37:0] sh;
`ifdef FFT16_ROUND_EN
        t = v + 38'sd262144;
`else
        t = v;
`endif
        sh = t >>> 19;
        if (sh > 38'sd32767) begin
            scale = 16'h7FFF;
        end else if (sh < -38'sd32768) begin
            scale = 16'h8000;
        end else begin
            scale = sh[15:0];
        end
    endfunction

    // Running sums including the sample presented this cycle.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            m_k[k]    = cnt * 4'(k);
            sum_re[k] = acc_re[k] + mul(xr, cos_lut(m_k[k])) + mul(xi, sin_lut(m_k[k]));
            sum_im[k] = acc_im[k] + mul(xi, cos_lut(m_k[k])) - mul(xr, sin_lut(m_k[k]));
        end
    end

    // Frame counter, accumulator bank, output bank and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            y_re_q    <= 16'd0;
            y_im_q    <= 16'd0;
            y_first_q <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                acc_re[k] <= 38'sd0;
                acc_im[k] <= 38'sd0;
            end
            for (int k = 1; k < 16; k++) begin
                bank_re[k] <= 16'd0;
                bank_im[k] <= 16'd0;
            end
        end else begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
                // Frame complete: bin 0 out now, bins 1..15 parked, restart sums.
                y_re_q    <= scale(sum_re[0]);
                y_im_q    <= scale(sum_im[0]);
                y_first_q <= 1'b1;
                for (int k = 0; k < 16; k++) begin
                    acc_re[k] <= 38'sd0;
                    acc_im[k] <= 38'sd0;
                end
                for (int k = 1; k < 16; k++) begin
                    bank_re[k] <= scale(sum_re[k]);
                    bank_im[k] <= scale(sum_im[k]);
                end
            end else begin
                // cnt=j shows bin j+1 of the previous frame.
                y_re_q    <= bank_re[cnt + 4'd1];
                y_im_q    <= bank_im[cnt + 4'd1];
                y_first_q <= 1'b0;
                for (int k = 0; k < 16; k++) begin
                    acc_re[k] <= sum_re[k];
                    acc_im[k] <= sum_im[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft16.sv
// tb_fft16: directed frames with hand-computed bins, checked by a scoreboard
// keyed on the edge number (counted from reset release) at which each bin is due.
module tb_fft16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft16_if bus ();

    fft16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Edge counter: first rising edge after release is edge 0.
    int edges_seen;
    always @(posedge clk or negedge reset) begin
        if (!reset) edges_seen = 0;
        else        edges_seen = edges_seen + 1;
    end

    // ---------------- scoreboard ----------------
    // entry = {edge[15:0], care, first, real[15:0], imag[15:0]}
    localparam int W = 50;
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input int edge_n, input logic care, input logic first,
                            input logic [15:0] re, input logic [15:0] im);
        exp_q.push_back({16'(edge_n), care, first, re, im});
    endtask

    // Monitor: compare the output shown after each edge against its due entry.
    logic [W-1:0] entry;
    always @(negedge clk) begin
        if (reset && exp_q.size() > 0) begin
            entry = exp_q[0];
            if (int'(entry[49:34]) < edges_seen - 1) begin
                void'(exp_q.pop_front());
                check($sformatf("missed_e%0d", entry[49:34]), 40'(edges_seen - 1), 40'(entry[49:34]));
            end else if (int'(entry[49:34]) == edges_seen - 1) begin
                void'(exp_q.pop_front());
                if (entry[33]) begin
                    check($sformatf("bin_e%0d", entry[49:34]),
                          {7'd0, bus.y_first, bus.y_real, bus.y_imag},
                          {7'd0, entry[32], entry[31:16], entry[15:0]});
                end else begin
                    check($sformatf("first_e%0d", entry[49:34]),
                          {39'd0, bus.y_first}, {39'd0, entry[32]});
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic [15:0] sr [16];
    logic [15:0] si [16];
    logic [15:0] er [16];
    logic [15:0] ei [16];
    logic [15:0] care;

    task automatic fill(input logic [15:0] re, input logic [15:0] im);
        for (int i = 0; i < 16; i++) begin
            sr[i] = re;
            si[i] = im;
            er[i] = 16'h0000;
            ei[i] = 16'h0000;
        end
        care = 16'hFFFF;
    endtask

    // Called at a negedge where the next rising edge is frame sample 0.
    task automatic run_frame();
        int base;
        base = edges_seen;
        for (int k = 0; k < 16; k++) begin
            push_exp(base + 15 + k, care[k], (k == 0), er[k], ei[k]);
        end
        for (int n = 0; n < 16; n++) begin
            bus.x_real = sr[n];
            bus.x_imag = si[n];
            @(negedge clk);
        end
    endtask

    // Outputs stay zero on edges 0..14 after release.
    task automatic push_idle();
        for (int e = 0; e < 15; e++) push_exp(e, 1'b1, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_y_real"},  {24'd0, bus.y_real}, 40'd0);
        check({tag, "_y_imag"},  {24'd0, bus.y_imag}, 40'd0);
        check({tag, "_y_first"}, {39'd0, bus.y_first}, 40'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        bus.x_real = 16'h0000;
        bus.x_imag = 16'h0000;
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        reset = 1'b1;
        push_idle();

        // Constant 1+j2: only bin 0 is nonzero.
        fill(16'h0001, 16'h0002);
        er[0] = 16'h0001; ei[0] = 16'h0002;
        run_frame();

        // Delayed impulse x[1]=0x1000: bins 0, 4, 8 checked.
        fill(16'h0000, 16'h0000);
        sr[1] = 16'h1000;
        er[0] = 16'h0100; ei[4] = 16'hFF00; er[8] = 16'hFF00;
        care  = 16'h0111;
        run_frame();

        // Constant real 0x0100: bin 0 = 0x0100, others zero.
        fill(16'h0100, 16'h0000);
        er[0] = 16'h0100;
        run_frame();

        // Impulse x[0]=0x4000: flat spectrum 0x0400.
        fill(16'h0000, 16'h0000);
        sr[0] = 16'h4000;
        for (int k = 0; k < 16; k++) er[k] = 16'h0400;
        run_frame();

        // Partial frame of large samples, aborted by reset at cnt=7.
        for (int n = 0; n < 7; n++) begin
            bus.x_real = 16'h2000;
            bus.x_imag = 16'h2000;
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_zero("held_reset");
        reset = 1'b1;
        push_idle();

        // Back-to-back frames 0x0001 then 0x0002 from release.
        fill(16'h0001, 16'h0000);
        er[0] = 16'h0001;
        run_frame();
        fill(16'h0002, 16'h0000);
        er[0] = 16'h0002;
        run_frame();

        // Drain with a bounded wait.
        bus.x_real = 16'h0000;
        bus.x_imag = 16'h0000;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
        #1 check("drain_pending", 40'(exp_q.size()), 40'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
